// File: rtl/n_driver_pkg.sv
// Shared widths and types for the n_driver request sequencer and its FIFO.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package n_driver_pkg;

    // Widths match module N's A and y ports.
    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;

    // The wait counter is 8 bits wide. TIMEOUT never exceeds 255, so the counter cannot wrap.
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

endpackage

// File: rtl/n_driver_fifo.sv
// Request FIFO for n_driver. Ports: push/din write, pop/dout read the head, full/empty status.
// Latency: a pushed entry is visible on dout the cycle after the push edge (no fall-through).
// Backpressure: a push while full or a pop while empty is ignored; the caller gates on full/empty.
module n_driver_fifo
    import n_driver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  req_t din,
    output req_t dout,
    output logic full,
    output logic empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    // Each pointer has one extra MSB, so full and empty can be told apart when the indices match.
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    req_t          r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    assign full  = (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]) && (r_wr_ptr[IW] != r_rd_ptr[IW]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign dout  = r_mem[r_rd_ptr[IW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // The storage needs no reset. Reset empties the FIFO, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[IW-1:0]] <= din;
    end

endmodule

// File: rtl/n_driver.sv
// n_driver: buffers {addr,data} requests and issues them to N one at a time (A/y, x strobe, z reply).
// Latency: x rises 2 cycles after the push cycle. rsp_valid follows x by 2..TIMEOUT+1 cycles.
// Backpressure: req_ready = !full. Responses are one-cycle pulses with no ready; z outside WAIT is ignored.
// Ports: clk/rst; req_valid/req_ready/req_addr/req_data in; A/x/y/z to N; rsp_valid/rsp_timeout/rsp_addr out.
module n_driver
    import n_driver_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic [ADDR_W-1:0] A,
    output logic              x,
    output logic [DATA_W-1:0] y,
    input  logic              z,
    output logic              rsp_valid,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] rsp_addr
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [ADDR_W-1:0] r_a;
    logic              r_x;
    logic [DATA_W-1:0] r_y;
    logic              r_rsp_valid;
    logic              r_rsp_timeout;
    logic [ADDR_W-1:0] r_rsp_addr;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    req_t w_din;
    req_t w_dout;

    assign req_ready = ~w_full;
    assign w_push    = req_valid & ~w_full;
    assign w_din     = '{addr: req_addr, data: req_data};
    // The head is popped in the same IDLE cycle that loads it into A/y.
    assign w_pop     = (r_state == IDLE) & ~w_empty;

    n_driver_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_wait_cnt    <= '0;
            r_a           <= '0;
            r_x           <= 1'b0;
            r_y           <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_addr    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_a     <= w_dout.addr;
                        r_y     <= w_dout.data;
                        r_x     <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_x        <= 1'b0;
                    r_wait_cnt <= '0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    // z takes priority over expiry in the last wait cycle.
                    if (z) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_addr    <= r_a;
                        r_state       <= RESPOND;
                    end else if (r_wait_cnt == LAST_CNT) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_addr    <= r_a;
                        r_state       <= RESPOND;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                RESPOND: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A and y hold the last issued request, so they are not cleared when the request completes.
    assign A           = r_a;
    assign x           = r_x;
    assign y           = r_y;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_timeout = r_rsp_timeout;
    assign rsp_addr    = r_rsp_addr;

endmodule

// File: tb/tb_n_driver.sv
// Self-checking bench for n_driver: directed scenarios plus a randomized run against a schedule model.
// Latency: n/a (testbench).
// Backpressure: requests are held on req_valid until they are accepted.
module tb_n_driver;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;
    localparam int MAXC    = 32768;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_addr  = '0;
    logic [3:0] req_data  = '0;
    logic [7:0] A;
    logic       x;
    logic [3:0] y;
    logic       z         = 1'b0;
    logic       rsp_valid;
    logic       rsp_timeout;
    logic [7:0] rsp_addr;

    n_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .A           (A),
        .x           (x),
        .y           (y),
        .z           (z),
        .rsp_valid   (rsp_valid),
        .rsp_timeout (rsp_timeout),
        .rsp_addr    (rsp_addr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // z stimulus mode: 0 = pulse at z_at cycles after the observed x, 1 = random, 2 = tied high.
    int z_mode  = 0;
    int z_at    = -1;
    int t_issue = -1;
    bit zhist [MAXC];

    // Observed issue and response events.
    int         iss_cyc[$];
    logic [7:0] iss_a[$];
    logic [3:0] iss_y[$];
    int         rsp_cyc[$];
    logic [7:0] rsp_a[$];
    logic       rsp_to[$];
    // Accepted pushes (cycle in which valid&ready held) and the model's expected schedule.
    int         pc[$];
    logic [7:0] pa[$];
    logic [3:0] pd[$];
    int         exp_iss[$];
    int         exp_rsp[$];
    logic       exp_to[$];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (x === 1'b1) begin
            iss_cyc.push_back(cyc); iss_a.push_back(A); iss_y.push_back(y);
            t_issue = cyc;
        end
        if (rsp_valid === 1'b1) begin
            rsp_cyc.push_back(cyc); rsp_a.push_back(rsp_addr); rsp_to.push_back(rsp_timeout);
        end
        case (z_mode)
            0:       z = (t_issue >= 0) && (cyc - t_issue == z_at);
            1:       z = ($urandom_range(0, 5) == 0);
            default: z = 1'b1;
        endcase
        if (cyc < MAXC) zhist[cyc] = z;
    endtask

    task automatic clear_logs();
        iss_cyc.delete(); iss_a.delete(); iss_y.delete();
        rsp_cyc.delete(); rsp_a.delete(); rsp_to.delete();
        pc.delete(); pa.delete(); pd.delete();
        t_issue = -1;
    endtask

    task automatic push_req(input logic [7:0] a, input logic [3:0] d);
        bit done = 0;
        req_valid = 1'b1; req_addr = a; req_data = d;
        for (int k = 0; k < 200 && !done; k++) begin
            if (req_ready === 1'b1) begin
                pc.push_back(cyc); pa.push_back(a); pd.push_back(d);
                done = 1;
            end
            tick();
        end
        req_valid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL push_accept addr=%h got no acceptance within 200 cycles, want accepted", a);
        end
    endtask

    task automatic drain(input int n, input int budget);
        for (int k = 0; k < budget && rsp_cyc.size() < n; k++) tick();
        repeat (4) tick();
    endtask

    // Reference schedule from the timing rules. The first request issues 2 cycles after its push
    // cycle, a later one no earlier than 2 cycles after the previous response. The response comes
    // one cycle after the first WAIT cycle (issue+1 .. issue+TIMEOUT) with z high, else at
    // issue+TIMEOUT+1 as a timeout.
    task automatic model_run();
        int  prev;
        int  iss;
        int  rsp;
        bit  to;
        exp_iss.delete(); exp_rsp.delete(); exp_to.delete();
        prev = -1000;
        foreach (pc[i]) begin
            iss = (pc[i] + 2 > prev + 2) ? pc[i] + 2 : prev + 2;
            rsp = iss + TIMEOUT + 1;
            to  = 1;
            for (int w = 1; w <= TIMEOUT; w++) begin
                if (to && (iss + w < MAXC) && zhist[iss + w]) begin
                    rsp = iss + w + 1;
                    to  = 0;
                end
            end
            exp_iss.push_back(iss); exp_rsp.push_back(rsp); exp_to.push_back(to);
            prev = rsp;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        tick(); tick();
        checks++;
        if ({A, x, y, rsp_valid, rsp_timeout, rsp_addr} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs got A=%h x=%b y=%h rv=%b rt=%b ra=%h want all zero",
                     A, x, y, rsp_valid, rsp_timeout, rsp_addr);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL reset_req_ready got %b want 1", req_ready);
        end
        // One request in flight in WAIT and two more queued, then reset.
        clear_logs(); z_mode = 0; z_at = -1;
        push_req(8'h11, 4'h1); push_req(8'h22, 4'h2); push_req(8'h33, 4'h3);
        tick();
        checks++;
        if (iss_cyc.size() != 1 || cyc - iss_cyc[0] != 2) begin
            failures++;
            $display("FAIL reset_setup got issues=%0d want 1 issue two cycles back", iss_cyc.size());
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({A, x, y, rsp_valid, rsp_timeout, rsp_addr} !== 23'd0) begin
            failures++;
            $display("FAIL reset_async got A=%h x=%b y=%h rv=%b rt=%b ra=%h want all zero",
                     A, x, y, rsp_valid, rsp_timeout, rsp_addr);
        end
        clear_logs();
        tick(); tick();
        rst = 1'b0;
        repeat (25) tick();
        checks++;
        if (iss_cyc.size() != 0 || rsp_cyc.size() != 0) begin
            failures++;
            $display("FAIL reset_discard got issues=%0d responses=%0d want 0 0", iss_cyc.size(), rsp_cyc.size());
        end
        checks++;
        if ({A, x, y} !== 13'd0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got A=%h x=%b y=%h ready=%b want 0 0 0 1", A, x, y, req_ready);
        end
    endtask

    task automatic test_single();
        clear_logs(); z_mode = 0; z_at = 3;
        push_req(8'hA5, 4'h3);
        drain(1, 60);
        checks++;
        if (iss_cyc.size() != 1 || rsp_cyc.size() != 1) begin
            failures++;
            $display("FAIL single_count got issues=%0d responses=%0d want 1 1", iss_cyc.size(), rsp_cyc.size());
        end else begin
            checks++;
            if (iss_cyc[0] != pc[0] + 2) begin
                failures++; $display("FAIL single_issue_latency got %0d want %0d", iss_cyc[0] - pc[0], 2);
            end
            checks++;
            if (iss_a[0] !== 8'hA5 || iss_y[0] !== 4'h3) begin
                failures++; $display("FAIL single_issue_data got A=%h y=%h want a5 3", iss_a[0], iss_y[0]);
            end
            checks++;
            if (rsp_cyc[0] != iss_cyc[0] + 4) begin
                failures++; $display("FAIL single_rsp_latency got %0d want 4", rsp_cyc[0] - iss_cyc[0]);
            end
            checks++;
            if (rsp_a[0] !== 8'hA5 || rsp_to[0] !== 1'b0) begin
                failures++; $display("FAIL single_rsp got addr=%h to=%b want a5 0", rsp_a[0], rsp_to[0]);
            end
        end
        checks++;
        if (A !== 8'hA5 || y !== 4'h3 || x !== 1'b0) begin
            failures++; $display("FAIL single_hold got A=%h y=%h x=%b want a5 3 0", A, y, x);
        end
    endtask

    // zat = -1: z never pulses. zat = 0: z pulses only in the ISSUE cycle. Both must time out.
    task automatic test_timeout_case(input int zat, input string tag);
        logic [7:0] a;
        logic [3:0] d;
        a = 8'($urandom); d = 4'($urandom);
        clear_logs(); z_mode = 0; z_at = zat;
        push_req(a, d);
        drain(1, 80);
        checks++;
        if (iss_cyc.size() != 1 || rsp_cyc.size() != 1) begin
            failures++;
            $display("FAIL %s_count got issues=%0d responses=%0d want 1 1", tag, iss_cyc.size(), rsp_cyc.size());
        end else begin
            checks++;
            if (rsp_cyc[0] - iss_cyc[0] != TIMEOUT + 1 || iss_cyc[0] != pc[0] + 2) begin
                failures++;
                $display("FAIL %s_latency got issue+%0d rsp+%0d want issue+2 rsp+%0d", tag,
                         iss_cyc[0] - pc[0], rsp_cyc[0] - iss_cyc[0], TIMEOUT + 1);
            end
            checks++;
            if (rsp_to[0] !== 1'b1 || rsp_a[0] !== a || iss_a[0] !== a || iss_y[0] !== d) begin
                failures++;
                $display("FAIL %s_rsp got to=%b ra=%h A=%h y=%h want 1 %h %h %h", tag,
                         rsp_to[0], rsp_a[0], iss_a[0], iss_y[0], a, a, d);
            end
        end
    endtask

    task automatic test_timeout();
        test_timeout_case(-1, "timeout");
    endtask

    task automatic test_issue_pulse();
        test_timeout_case(0, "issue_pulse");
    endtask

    task automatic test_back_to_back();
        int n;
        int last_iss;
        int popped;
        int occ;
        bit exp_rdy;
        n = DEPTH + 2;
        last_iss = -1000;
        clear_logs(); z_mode = 2; exp_iss.delete();
        // req_valid is held high. The FIFO head is popped two cycles after its push, so with z
        // tied high the FIFO fills once DEPTH entries wait behind the request in flight.
        for (int k = 0; k < 200 && pc.size() < n; k++) begin
            req_valid = 1'b1;
            req_addr  = 8'h40 + 8'(pc.size());
            req_data  = 4'(pc.size());
            popped = 0;
            foreach (exp_iss[i]) if (exp_iss[i] <= cyc) popped++;
            occ = pc.size() - popped;
            exp_rdy = (occ < DEPTH);
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL b2b_ready cyc=%0d occupancy=%0d got %b want %b", cyc, occ, req_ready, exp_rdy);
            end
            if (exp_rdy) begin
                pc.push_back(cyc); pa.push_back(req_addr); pd.push_back(req_data);
                exp_iss.push_back((cyc + 2 > last_iss + 4) ? cyc + 2 : last_iss + 4);
                last_iss = exp_iss[$];
            end
            tick();
        end
        req_valid = 1'b0;
        drain(n, 200);
        z_mode = 0; z_at = -1;
        checks++;
        if (iss_cyc.size() != n || rsp_cyc.size() != n) begin
            failures++;
            $display("FAIL b2b_count got issues=%0d responses=%0d want %0d", iss_cyc.size(), rsp_cyc.size(), n);
        end
        for (int i = 0; i < n && i < iss_cyc.size() && i < rsp_cyc.size() && i < exp_iss.size(); i++) begin
            checks++;
            if (iss_cyc[i] != exp_iss[i] || iss_a[i] !== pa[i] || iss_y[i] !== pd[i]) begin
                failures++;
                $display("FAIL b2b_issue[%0d] got cyc=%0d A=%h y=%h want cyc=%0d A=%h y=%h",
                         i, iss_cyc[i], iss_a[i], iss_y[i], exp_iss[i], pa[i], pd[i]);
            end
            checks++;
            if (rsp_cyc[i] != exp_iss[i] + 2 || rsp_a[i] !== pa[i] || rsp_to[i] !== 1'b0) begin
                failures++;
                $display("FAIL b2b_rsp[%0d] got cyc=%0d addr=%h to=%b want cyc=%0d addr=%h to=0",
                         i, rsp_cyc[i], rsp_a[i], rsp_to[i], exp_iss[i] + 2, pa[i]);
            end
            if (i > 0) begin
                checks++;
                if (iss_cyc[i] - iss_cyc[i-1] != 4) begin
                    failures++;
                    $display("FAIL b2b_period[%0d] got %0d want 4", i, iss_cyc[i] - iss_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_push_pop();
        clear_logs(); z_mode = 0; z_at = 2;
        push_req(8'hC1, 4'h1);
        push_req(8'hC2, 4'h2);
        for (int k = 0; k < 50 && rsp_cyc.size() == 0; k++) tick();
        // The first request just responded. Next cycle is IDLE with one entry queued, so the
        // push below lands on the same edge as the pop.
        tick();
        push_req(8'hC3, 4'h3);
        drain(3, 200);
        z_at = -1;
        model_run();
        checks++;
        if (iss_cyc.size() < 2 || iss_cyc[1] != pc[2] + 1) begin
            failures++;
            $display("FAIL pushpop_same_edge got issues=%0d want second issue one cycle after third push",
                     iss_cyc.size());
        end
        checks++;
        if (iss_cyc.size() != 3 || rsp_cyc.size() != 3) begin
            failures++;
            $display("FAIL pushpop_count got issues=%0d responses=%0d want 3 3", iss_cyc.size(), rsp_cyc.size());
        end
        for (int i = 0; i < pc.size() && i < iss_cyc.size() && i < rsp_cyc.size(); i++) begin
            checks++;
            if (iss_cyc[i] != exp_iss[i] || iss_a[i] !== pa[i] || iss_y[i] !== pd[i] ||
                rsp_cyc[i] != exp_rsp[i] || rsp_a[i] !== pa[i] || rsp_to[i] !== exp_to[i]) begin
                failures++;
                $display("FAIL pushpop[%0d] got iss=%0d A=%h y=%h rsp=%0d ra=%h to=%b want %0d %h %h %0d %h %b",
                         i, iss_cyc[i], iss_a[i], iss_y[i], rsp_cyc[i], rsp_a[i], rsp_to[i],
                         exp_iss[i], pa[i], pd[i], exp_rsp[i], pa[i], exp_to[i]);
            end
        end
    endtask

    task automatic test_random();
        clear_logs(); z_mode = 1;
        for (int k = 0; k < 400; k++) begin
            req_valid = ($urandom_range(0, 2) == 0);
            req_addr  = 8'($urandom);
            req_data  = 4'($urandom);
            if (req_valid === 1'b1 && req_ready === 1'b1) begin
                pc.push_back(cyc); pa.push_back(req_addr); pd.push_back(req_data);
            end
            tick();
        end
        req_valid = 1'b0;
        drain(pc.size(), 3000);
        z_mode = 0; z_at = -1;
        model_run();
        checks++;
        if (iss_cyc.size() != pc.size() || rsp_cyc.size() != pc.size()) begin
            failures++;
            $display("FAIL rand_count got issues=%0d responses=%0d want %0d", iss_cyc.size(), rsp_cyc.size(), pc.size());
        end
        for (int i = 0; i < pc.size() && i < iss_cyc.size() && i < rsp_cyc.size(); i++) begin
            checks++;
            if (iss_cyc[i] != exp_iss[i] || iss_a[i] !== pa[i] || iss_y[i] !== pd[i] ||
                rsp_cyc[i] != exp_rsp[i] || rsp_a[i] !== pa[i] || rsp_to[i] !== exp_to[i]) begin
                failures++;
                $display("FAIL rand[%0d] got iss=%0d A=%h y=%h rsp=%0d ra=%h to=%b want %0d %h %h %0d %h %b",
                         i, iss_cyc[i], iss_a[i], iss_y[i], rsp_cyc[i], rsp_a[i], rsp_to[i],
                         exp_iss[i], pa[i], pd[i], exp_rsp[i], pa[i], exp_to[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_issue_pulse();
        test_back_to_back();
        test_push_pop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog got no completion by cycle %0d want completion", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
